// File: rtl/geri_yaz_hakem_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// The source encodings are also used by the tracing monitor.
package geri_yaz_hakem_pkg;

    localparam int VERI_BIT_VARS     = 32;
    localparam int ADRES_BIT_VARS    = 5;
    localparam int ACLIK_SINIRI_VARS = 4;

    typedef enum logic [1:0] {
        KAYNAK_GY  = 2'd0,
        KAYNAK_BOL = 2'd1,
        KAYNAK_BEL = 2'd2,
        KAYNAK_YOK = 2'd3
    } kaynak_e;

    // Round-robin only ever alternates between the two buffered sources.
    function automatic kaynak_e karsi_kaynak(input kaynak_e k);
        return (k == KAYNAK_BOL) ? KAYNAK_BEL : KAYNAK_BOL;
    endfunction

endpackage

// File: rtl/geri_yaz_hakem_if.sv
// Write-port bundle: pipeline writeback, divider and load handshakes,
// register-file write port and the stall request.
interface geri_yaz_hakem_if
    import geri_yaz_hakem_pkg::*;
#(
    parameter int VERI_BIT  = VERI_BIT_VARS,
    parameter int ADRES_BIT = ADRES_BIT_VARS
);
    logic                 gy_yaz_yazmac_i;
    logic [ADRES_BIT-1:0] gy_yaz_adres_i;
    logic [VERI_BIT-1:0]  gy_yaz_deger_i;

    logic                 bol_gecerli_i;
    logic [ADRES_BIT-1:0] bol_adres_i;
    logic [VERI_BIT-1:0]  bol_deger_i;
    logic                 bol_hazir_o;

    logic                 bel_gecerli_i;
    logic [ADRES_BIT-1:0] bel_adres_i;
    logic [VERI_BIT-1:0]  bel_deger_i;
    logic                 bel_hazir_o;

    logic                 cyo_yaz_yazmac_o;
    logic [ADRES_BIT-1:0] cyo_yaz_adres_o;
    logic [VERI_BIT-1:0]  cyo_yaz_deger_o;
    logic                 cek_durdur_o;

    modport master (
        output gy_yaz_yazmac_i, gy_yaz_adres_i, gy_yaz_deger_i,
        output bol_gecerli_i, bol_adres_i, bol_deger_i,
        output bel_gecerli_i, bel_adres_i, bel_deger_i,
        input  bol_hazir_o, bel_hazir_o,
        input  cyo_yaz_yazmac_o, cyo_yaz_adres_o, cyo_yaz_deger_o,
        input  cek_durdur_o
    );

    modport slave (
        input  gy_yaz_yazmac_i, gy_yaz_adres_i, gy_yaz_deger_i,
        input  bol_gecerli_i, bol_adres_i, bol_deger_i,
        input  bel_gecerli_i, bel_adres_i, bel_deger_i,
        output bol_hazir_o, bel_hazir_o,
        output cyo_yaz_yazmac_o, cyo_yaz_adres_o, cyo_yaz_deger_o,
        output cek_durdur_o
    );

endinterface

// File: rtl/geri_yaz_hakem_tampon.sv
// One-entry holding buffer for a multi-cycle result: valid/ready capture,
// x0 discard and the starvation wait counter.
module geri_yaz_tampon
    import geri_yaz_hakem_pkg::*;
#(
    parameter int VERI_BIT     = VERI_BIT_VARS,
    parameter int ADRES_BIT    = ADRES_BIT_VARS,
    parameter int ACLIK_SINIRI = ACLIK_SINIRI_VARS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 gecerli_i,
    input  logic [ADRES_BIT-1:0] adres_i,
    input  logic [VERI_BIT-1:0]  deger_i,
    output logic                 hazir_o,
    input  logic                 verildi_i,
    output logic                 dolu_o,
    output logic [ADRES_BIT-1:0] adres_o,
    output logic [VERI_BIT-1:0]  deger_o,
    output logic                 sayac_sinirda_o
);

    localparam int SAYAC_BIT = $clog2(ACLIK_SINIRI + 1);
    localparam logic [SAYAC_BIT-1:0] SINIR = SAYAC_BIT'(ACLIK_SINIRI);

    logic                 dolu_q, dolu_d;
    logic [ADRES_BIT-1:0] adres_q, adres_d;
    logic [VERI_BIT-1:0]  deger_q, deger_d;
    logic [SAYAC_BIT-1:0] sayac_q, sayac_d;
    logic                 sifir_adres;

    assign sifir_adres = (adres_q == '0);

    // An x0 entry never competes for the port, so it is not "full" to the arbiter.
    assign hazir_o         = ~dolu_q;
    assign dolu_o          = dolu_q & ~sifir_adres;
    assign adres_o         = adres_q;
    assign deger_o         = deger_q;
    assign sayac_sinirda_o = (sayac_q == SINIR);

    always_comb begin
        dolu_d  = dolu_q;
        adres_d = adres_q;
        deger_d = deger_q;
        sayac_d = sayac_q;

        if (dolu_q) begin
            if (verildi_i || sifir_adres) begin
                dolu_d = 1'b0;
            end
        end else if (gecerli_i) begin
            dolu_d  = 1'b1;
            adres_d = adres_i;
            deger_d = deger_i;
        end

        if (!dolu_o || verildi_i) begin
            sayac_d = '0;
        end else if (sayac_q != SINIR) begin
            sayac_d = sayac_q + SAYAC_BIT'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dolu_q  <= 1'b0;
            adres_q <= '0;
            deger_q <= '0;
            sayac_q <= '0;
        end else begin
            dolu_q  <= dolu_d;
            adres_q <= adres_d;
            deger_q <= deger_d;
            sayac_q <= sayac_d;
        end
    end

endmodule

// File: rtl/geri_yaz_hakem.sv
// Register-file write-port arbiter: pipeline first, then the divider and
// load buffers in round-robin order, with a stall request against starvation.
module geri_yaz_hakem
    import geri_yaz_hakem_pkg::*;
#(
    parameter int VERI_BIT     = VERI_BIT_VARS,
    parameter int ADRES_BIT    = ADRES_BIT_VARS,
    parameter int ACLIK_SINIRI = ACLIK_SINIRI_VARS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    geri_yaz_hakem_if.slave   yaz_if
);

    logic                 bol_hazir, bel_hazir;
    logic                 bol_dolu, bel_dolu;
    logic                 bol_aday, bel_aday;
    logic                 bol_ver, bel_ver;
    logic                 bol_sinirda, bel_sinirda;
    logic [ADRES_BIT-1:0] bol_adres, bel_adres;
    logic [VERI_BIT-1:0]  bol_deger, bel_deger;

    kaynak_e              isaret_q, isaret_d;
    kaynak_e              secilen;
    logic                 cek_q, cek_d;

    logic                 yazmac;
    logic [ADRES_BIT-1:0] adres;
    logic [VERI_BIT-1:0]  deger;

    geri_yaz_tampon #(
        .VERI_BIT     (VERI_BIT),
        .ADRES_BIT    (ADRES_BIT),
        .ACLIK_SINIRI (ACLIK_SINIRI)
    ) u_bol_tampon (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .gecerli_i       (yaz_if.bol_gecerli_i),
        .adres_i         (yaz_if.bol_adres_i),
        .deger_i         (yaz_if.bol_deger_i),
        .hazir_o         (bol_hazir),
        .verildi_i       (bol_ver),
        .dolu_o          (bol_dolu),
        .adres_o         (bol_adres),
        .deger_o         (bol_deger),
        .sayac_sinirda_o (bol_sinirda)
    );

    geri_yaz_tampon #(
        .VERI_BIT     (VERI_BIT),
        .ADRES_BIT    (ADRES_BIT),
        .ACLIK_SINIRI (ACLIK_SINIRI)
    ) u_bel_tampon (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .gecerli_i       (yaz_if.bel_gecerli_i),
        .adres_i         (yaz_if.bel_adres_i),
        .deger_i         (yaz_if.bel_deger_i),
        .hazir_o         (bel_hazir),
        .verildi_i       (bel_ver),
        .dolu_o          (bel_dolu),
        .adres_o         (bel_adres),
        .deger_o         (bel_deger),
        .sayac_sinirda_o (bel_sinirda)
    );

    // Buffered results must not reach the register file while reset discards them.
    assign bol_aday = bol_dolu & ~rst_i;
    assign bel_aday = bel_dolu & ~rst_i;

    always_comb begin
        secilen  = KAYNAK_YOK;
        isaret_d = isaret_q;

        if (yaz_if.gy_yaz_yazmac_i) begin
            secilen = KAYNAK_GY;
        end else if (bol_aday && bel_aday) begin
            secilen  = isaret_q;
            isaret_d = karsi_kaynak(isaret_q);
        end else if (bol_aday) begin
            secilen = KAYNAK_BOL;
        end else if (bel_aday) begin
            secilen = KAYNAK_BEL;
        end

        bol_ver = (secilen == KAYNAK_BOL);
        bel_ver = (secilen == KAYNAK_BEL);
        cek_d   = bol_sinirda | bel_sinirda;
    end

    always_comb begin
        yazmac = 1'b0;
        adres  = '0;
        deger  = '0;
        case (secilen)
            KAYNAK_GY: begin
                // x0 still takes the port but never writes or bypasses.
                yazmac = (yaz_if.gy_yaz_adres_i != '0);
                adres  = yaz_if.gy_yaz_adres_i;
                deger  = yaz_if.gy_yaz_deger_i;
            end
            KAYNAK_BOL: begin
                yazmac = 1'b1;
                adres  = bol_adres;
                deger  = bol_deger;
            end
            KAYNAK_BEL: begin
                yazmac = 1'b1;
                adres  = bel_adres;
                deger  = bel_deger;
            end
            default: begin
                yazmac = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isaret_q <= KAYNAK_BOL;
            cek_q    <= 1'b0;
        end else begin
            isaret_q <= isaret_d;
            cek_q    <= cek_d;
        end
    end

    assign yaz_if.bol_hazir_o      = bol_hazir;
    assign yaz_if.bel_hazir_o      = bel_hazir;
    assign yaz_if.cyo_yaz_yazmac_o = yazmac;
    assign yaz_if.cyo_yaz_adres_o  = adres;
    assign yaz_if.cyo_yaz_deger_o  = deger;
    assign yaz_if.cek_durdur_o     = cek_q;

endmodule
